// File: rtl/h_cache_replay.sv
`default_nettype none
// ============================================================================
// Module   : h_cache_replay
// Brief    : Per-column pre-activation (H) cache. Captures H values from two
//            systolic columns during the forward pass and replays them, one
//            per gradient beat, aligned with the gradient for the two-column
//            leaky-ReLU derivative stage.
// Revision : 1.0 - initial release
// ============================================================================
module h_cache_replay #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hc_start_capture_in,
   input  logic                     hc_start_replay_in,
   input  logic                     hc_H_valid_1_in,
   input  logic                     hc_H_valid_2_in,
   input  logic [15:0]              hc_H_1_in,
   input  logic [15:0]              hc_H_2_in,
   input  logic                     hc_grad_valid_1_in,
   input  logic                     hc_grad_valid_2_in,
   input  logic [15:0]              hc_grad_1_in,
   input  logic [15:0]              hc_grad_2_in,
   output logic                     hc_d_valid_1_out,
   output logic                     hc_d_valid_2_out,
   output logic [15:0]              hc_d_data_1_out,
   output logic [15:0]              hc_d_data_2_out,
   output logic [15:0]              hc_d_H_1_out,
   output logic [15:0]              hc_d_H_2_out,
   output logic [$clog2(DEPTH):0]   hc_count_1_out,
   output logic [$clog2(DEPTH):0]   hc_count_2_out,
   output logic [1:0]               hc_state_out,
   output logic                     hc_done_out,
   output logic                     hc_overflow_out,
   output logic                     hc_underflow_out
);

   localparam int          c_AW      = $clog2(DEPTH);
   localparam int          c_CW      = c_AW + 1;
   localparam logic [1:0]  c_IDLE    = 2'd0;
   localparam logic [1:0]  c_CAPTURE = 2'd1;
   localparam logic [1:0]  c_REPLAY  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic             w_capture;
   logic             w_replay;
   logic             w_clear;
   logic             w_done_next;
   logic             r_done;
   logic             r_overflow;
   logic             r_underflow;

   // Column-indexed views of the per-column ports
   logic [1:0]       w_h_valid;
   logic [1:0]       w_grad_valid;
   logic [15:0]      w_h    [2];
   logic [15:0]      w_grad [2];
   logic [1:0]       w_empty;
   logic [1:0]       w_ovf_evt;
   logic [1:0]       w_unf_evt;
   logic [1:0]       w_d_valid;
   logic [15:0]      w_d_data [2];
   logic [15:0]      w_d_h    [2];
   logic [c_CW-1:0]  w_count  [2];

   assign w_h_valid    = {hc_H_valid_2_in, hc_H_valid_1_in};
   assign w_grad_valid = {hc_grad_valid_2_in, hc_grad_valid_1_in};
   assign w_h[0]       = hc_H_1_in;
   assign w_h[1]       = hc_H_2_in;
   assign w_grad[0]    = hc_grad_1_in;
   assign w_grad[1]    = hc_grad_2_in;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode; start_capture has priority over start_replay
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (hc_start_capture_in)     w_state_next = c_CAPTURE;
            else if (hc_start_replay_in) w_state_next = c_REPLAY;
         end
         c_CAPTURE: begin
            if (!hc_start_capture_in && hc_start_replay_in) w_state_next = c_REPLAY;
         end
         c_REPLAY: begin
            if (w_done_next) w_state_next = c_IDLE;
         end
         default: w_state_next = c_IDLE;
      endcase
   end

   // State-derived controls: a start_capture pulse clears and suppresses pushes
   always_comb begin
      w_clear      = hc_start_capture_in && (r_state == c_IDLE || r_state == c_CAPTURE);
      w_capture    = (r_state == c_CAPTURE) && !hc_start_capture_in;
      w_replay     = (r_state == c_REPLAY);
      w_done_next  = w_replay && (&w_empty) && !(|w_grad_valid);
      hc_state_out = r_state;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_col
      logic [15:0]      r_mem [DEPTH];
      logic [c_AW-1:0]  r_wr_ptr;
      logic [c_AW-1:0]  r_rd_ptr;
      logic [c_CW-1:0]  r_count;
      logic             r_d_valid;
      logic [15:0]      r_d_data;
      logic [15:0]      r_d_h;
      logic             w_full;
      logic             w_push;
      logic             w_pop;
      logic             w_beat;

      assign w_full         = (r_count == c_CW'(DEPTH));
      assign w_empty[gi]    = (r_count == '0);
      assign w_push         = w_capture && w_h_valid[gi] && !w_full;
      assign w_beat         = w_replay && w_grad_valid[gi];
      assign w_pop          = w_beat && !w_empty[gi];
      assign w_ovf_evt[gi]  = w_capture && w_h_valid[gi] && w_full;
      assign w_unf_evt[gi]  = w_beat && w_empty[gi];

      // Storage array; contents are only ever read behind a non-zero count
      always_ff @(posedge clk) begin
         if (w_push) r_mem[r_wr_ptr] <= w_h[gi];
      end

      // Pointers and occupancy; pointer width gives modulo-DEPTH wrap
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
            r_count  <= r_count + c_CW'(1);
         end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count  <= r_count - c_CW'(1);
         end
      end

      // Aligned output beat; zero whenever no beat, H is zero on underflow
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_d_valid <= 1'b0;
            r_d_data  <= '0;
            r_d_h     <= '0;
         end else begin
            r_d_valid <= w_beat;
            r_d_data  <= w_beat ? w_grad[gi] : 16'h0000;
            r_d_h     <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
         end
      end

      assign w_d_valid[gi] = r_d_valid;
      assign w_d_data[gi]  = r_d_data;
      assign w_d_h[gi]     = r_d_h;
      assign w_count[gi]   = r_count;
   end

   // Sticky error flags and the replay-complete pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_done_next;
         if (w_clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            if (|w_ovf_evt) r_overflow  <= 1'b1;
            if (|w_unf_evt) r_underflow <= 1'b1;
         end
      end
   end

   assign hc_d_valid_1_out = w_d_valid[0];
   assign hc_d_valid_2_out = w_d_valid[1];
   assign hc_d_data_1_out  = w_d_data[0];
   assign hc_d_data_2_out  = w_d_data[1];
   assign hc_d_H_1_out     = w_d_h[0];
   assign hc_d_H_2_out     = w_d_h[1];
   assign hc_count_1_out   = w_count[0];
   assign hc_count_2_out   = w_count[1];
   assign hc_done_out      = r_done;
   assign hc_overflow_out  = r_overflow;
   assign hc_underflow_out = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_h_cache_replay.sv
`default_nettype none
// ============================================================================
// Module   : tb_h_cache_replay
// Brief    : Self-checking bench for h_cache_replay: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_h_cache_replay;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sc  = 1'b0;
   logic              sr  = 1'b0;
   logic [1:0]        hv  = '0;
   logic [1:0]        gv  = '0;
   logic [15:0]       hd [2];
   logic [15:0]       gd [2];

   logic              d_valid_1, d_valid_2, done, ovf, unf;
   logic [15:0]       d_data_1, d_data_2, d_h_1, d_h_2;
   logic [CW-1:0]     count_1, count_2;
   logic [1:0]        state;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int          m_state;
   logic [15:0] q [2][$];
   bit          m_ovf, m_unf, m_done;
   bit          e_valid [2];
   logic [15:0] e_data  [2];
   logic [15:0] e_h     [2];

   h_cache_replay #(.DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .hc_start_capture_in (sc),
      .hc_start_replay_in  (sr),
      .hc_H_valid_1_in     (hv[0]),
      .hc_H_valid_2_in     (hv[1]),
      .hc_H_1_in           (hd[0]),
      .hc_H_2_in           (hd[1]),
      .hc_grad_valid_1_in  (gv[0]),
      .hc_grad_valid_2_in  (gv[1]),
      .hc_grad_1_in        (gd[0]),
      .hc_grad_2_in        (gd[1]),
      .hc_d_valid_1_out    (d_valid_1),
      .hc_d_valid_2_out    (d_valid_2),
      .hc_d_data_1_out     (d_data_1),
      .hc_d_data_2_out     (d_data_2),
      .hc_d_H_1_out        (d_h_1),
      .hc_d_H_2_out        (d_h_2),
      .hc_count_1_out      (count_1),
      .hc_count_2_out      (count_2),
      .hc_state_out        (state),
      .hc_done_out         (done),
      .hc_overflow_out     (ovf),
      .hc_underflow_out    (unf)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      q[0].delete();
      q[1].delete();
      m_ovf = 0; m_unf = 0; m_done = 0;
      for (int c = 0; c < 2; c++) begin
         e_valid[c] = 0; e_data[c] = '0; e_h[c] = '0;
      end
   endtask

   // One clock of behaviour, judged on the inputs present at the edge
   task automatic model_step();
      m_done = 0;
      for (int c = 0; c < 2; c++) begin
         e_valid[c] = 0; e_data[c] = '0; e_h[c] = '0;
      end
      case (m_state)
         0: begin
            if (sc) begin
               q[0].delete(); q[1].delete(); m_ovf = 0; m_unf = 0; m_state = 1;
            end else if (sr) m_state = 2;
         end
         1: begin
            if (sc) begin
               q[0].delete(); q[1].delete(); m_ovf = 0; m_unf = 0;
            end else begin
               for (int c = 0; c < 2; c++)
                  if (hv[c]) begin
                     if (q[c].size() < DEPTH) q[c].push_back(hd[c]);
                     else m_ovf = 1;
                  end
               if (sr) m_state = 2;
            end
         end
         default: begin
            if (q[0].size() == 0 && q[1].size() == 0 && gv == 2'b00) begin
               m_state = 0; m_done = 1;
            end else begin
               for (int c = 0; c < 2; c++)
                  if (gv[c]) begin
                     e_valid[c] = 1;
                     e_data[c]  = gd[c];
                     if (q[c].size() > 0) e_h[c] = q[c].pop_front();
                     else m_unf = 1;
                  end
            end
         end
      endcase
   endtask

   task automatic check_all(input string ph);
      check_value({ph, ":state"},  32'(state),     32'(m_state));
      check_value({ph, ":count1"}, 32'(count_1),   32'(q[0].size()));
      check_value({ph, ":count2"}, 32'(count_2),   32'(q[1].size()));
      check_value({ph, ":done"},   32'(done),      32'(m_done));
      check_value({ph, ":ovf"},    32'(ovf),       32'(m_ovf));
      check_value({ph, ":unf"},    32'(unf),       32'(m_unf));
      check_value({ph, ":valid1"}, 32'(d_valid_1), 32'(e_valid[0]));
      check_value({ph, ":data1"},  32'(d_data_1),  32'(e_data[0]));
      check_value({ph, ":h1"},     32'(d_h_1),     32'(e_h[0]));
      check_value({ph, ":valid2"}, 32'(d_valid_2), 32'(e_valid[1]));
      check_value({ph, ":data2"},  32'(d_data_2),  32'(e_data[1]));
      check_value({ph, ":h2"},     32'(d_h_2),     32'(e_h[1]));
   endtask

   task automatic drive(input bit s_c, input bit s_r, input logic [1:0] h_v,
                        input logic [15:0] h1, input logic [15:0] h2,
                        input logic [1:0] g_v, input logic [15:0] g1, input logic [15:0] g2);
      sc = s_c; sr = s_r; hv = h_v; hd[0] = h1; hd[1] = h2;
      gv = g_v; gd[0] = g1; gd[1] = g2;
   endtask

   task automatic cycle(input string ph);
      @(posedge clk);
      model_step();
      #1;
      check_all(ph);
   endtask

   task automatic step(input string ph, input bit s_c, input bit s_r, input logic [1:0] h_v,
                       input logic [15:0] h1, input logic [15:0] h2,
                       input logic [1:0] g_v, input logic [15:0] g1, input logic [15:0] g2);
      drive(s_c, s_r, h_v, h1, h2, g_v, g1, g2);
      cycle(ph);
   endtask

   task automatic idle(input string ph, input int n);
      for (int i = 0; i < n; i++) step(ph, 0, 0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
   endtask

   task automatic async_reset(input string ph);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(ph);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      hd[0] = '0; hd[1] = '0; gd[0] = '0; gd[1] = '0;
      model_reset();
      #2;
      check_all("reset");
      rst = 1'b0;

      // Basic capture and replay on column 1
      step("t1_cap", 1, 0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t1_push", 0, 0, 2'b01, 16'h0100, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t1_push", 0, 0, 2'b01, 16'hFF80, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t1_push", 0, 0, 2'b01, 16'h0280, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t1_rep", 0, 1, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t1_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'h0010, 16'h0);
      check_value("t1_first_data", 32'(d_data_1), 32'h0010);
      check_value("t1_first_h",    32'(d_h_1),    32'h0100);
      step("t1_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'h0020, 16'h0);
      check_value("t1_second_h",   32'(d_h_1),    32'hFF80);
      step("t1_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'h0030, 16'h0);
      check_value("t1_third_h",    32'(d_h_1),    32'h0280);
      idle("t1_exit", 1);
      check_value("t1_done",  32'(done),  32'h1);
      check_value("t1_state", 32'(state), 32'h0);
      idle("t1_after", 1);

      // Column 2 one cycle behind column 1, both in capture and replay
      step("t2_cap", 1, 0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t2_push", 0, 0, 2'b01, 16'h1111, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t2_push", 0, 0, 2'b11, 16'h2222, 16'hAAAA, 2'b00, 16'h0, 16'h0);
      step("t2_push", 0, 1, 2'b10, 16'h0, 16'hBBBB, 2'b00, 16'h0, 16'h0);
      step("t2_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'h0001, 16'h0);
      step("t2_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0002, 16'h0003);
      check_value("t2_v1", 32'(d_valid_1), 32'h1);
      check_value("t2_h2", 32'(d_h_2),     32'hAAAA);
      step("t2_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b10, 16'h0, 16'h0004);
      check_value("t2_v1_off", 32'(d_valid_1), 32'h0);
      check_value("t2_h2_b",   32'(d_h_2),     32'hBBBB);
      idle("t2_exit", 2);

      // Overflow on column 1
      step("t3_cap", 1, 0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      for (int i = 1; i <= 5; i++)
         step("t3_push", 0, 0, 2'b01, 16'(i * 16'h0101), 16'h0, 2'b00, 16'h0, 16'h0);
      check_value("t3_count", 32'(count_1), 32'(DEPTH));
      check_value("t3_ovf",   32'(ovf),     32'h1);
      step("t3_rep", 0, 1, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      for (int i = 1; i <= 4; i++)
         step("t3_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'(i), 16'h0);
      check_value("t3_last_h", 32'(d_h_1), 32'h0404);
      idle("t3_exit", 2);

      // Underflow on empty column 2, column 1 holds one entry
      step("t4_cap", 1, 0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t4_push", 0, 1, 2'b01, 16'h5A5A, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t4_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b10, 16'h0, 16'h0040);
      check_value("t4_v2",   32'(d_valid_2), 32'h1);
      check_value("t4_d2",   32'(d_data_2),  32'h0040);
      check_value("t4_h2",   32'(d_h_2),     32'h0000);
      check_value("t4_unf",  32'(unf),       32'h1);
      check_value("t4_cnt1", 32'(count_1),   32'h1);
      step("t4_drain", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'h0007, 16'h0);
      check_value("t4_h1", 32'(d_h_1), 32'h5A5A);
      idle("t4_exit", 2);

      // Both start pulses together in IDLE
      step("t5_both", 1, 1, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      check_value("t5_state", 32'(state), 32'h1);
      check_value("t5_unf",   32'(unf),   32'h0);

      // Asynchronous reset in the middle of a replay
      step("t6_cap", 1, 0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      for (int i = 0; i < 4; i++)
         step("t6_push", 0, 0, 2'b01, 16'(16'h0A00 + i), 16'h0, 2'b00, 16'h0, 16'h0);
      step("t6_rep", 0, 1, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t6_g", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'h0099, 16'h0);
      drive(0, 0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      async_reset("t6_rst");
      check_value("t6_rst_valid", 32'(d_valid_1), 32'h0);
      check_value("t6_rst_count", 32'(count_1),   32'h0);
      step("t6_rep2", 0, 1, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
      step("t6_g2", 0, 0, 2'b00, 16'h0, 16'h0, 2'b01, 16'h0055, 16'h0);
      check_value("t6_unf", 32'(unf), 32'h1);
      idle("t6_exit", 2);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
               2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
               2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
